// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: position counters, sync pulses, display enable,
// a one-cycle frame-start strobe and a modulo-256 frame counter.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_EN,
  output logic [9:0] o_X,
  output logic [9:0] o_Y,
  output logic       o_DE,
  output logic       o_HSYNC,
  output logic       o_VSYNC,
  output logic       o_FRAME_START,
  output logic [7:0] o_FRAME_CNT
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HMax     = 10'(HTotal - 1);
  localparam logic [9:0] VMax     = 10'(VTotal - 1);
  localparam logic [9:0] HActEnd  = 10'(H_ACTIVE);
  localparam logic [9:0] VActEnd  = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       de_q, de_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_EN) begin
      if (x_q == HMax) begin
        x_d = '0;
        y_d = (y_q == VMax) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decodes use the next position so they line up with the registered counters.
    de_d  = (x_d < HActEnd) && (y_d < VActEnd);
    hs_d  = ((x_d >= HsStart) && (x_d < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vs_d  = ((y_d >= VsStart) && (y_d < VsEnd)) ? SYNC_POL : ~SYNC_POL;
    fs_d  = i_EN && (x_q == HMax) && (y_q == VMax);
    cnt_d = cnt_q + {7'd0, fs_d};
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      x_q   <= HMax;
      y_q   <= VMax;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_X           = x_q;
  assign o_Y           = y_q;
  assign o_DE          = de_q;
  assign o_HSYNC       = hs_q;
  assign o_VSYNC       = vs_q;
  assign o_FRAME_START = fs_q;
  assign o_FRAME_CNT   = cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a tiny active-high instance,
// both compared every cycle against a position-from-edge-count model.
module tb_vga_sync_gen;

  localparam int unsigned AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int unsigned AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int unsigned BHA = 8,   BHF = 2,  BHS = 2,  BHB = 2;
  localparam int unsigned BVA = 4,   BVF = 1,  BVS = 1,  BVB = 1;
  localparam longint unsigned FA = 800 * 525;
  localparam longint unsigned FB = 14 * 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [9:0] xa, ya, xb, yb;
  logic       dea, hsa, vsa, fsa, deb, hsb, vsb, fsb;
  logic [7:0] cnta, cntb;

  vga_sync_gen u_dut_a (
    .i_CLK(clk), .i_RST(rst_a), .i_EN(en_a),
    .o_X(xa), .o_Y(ya), .o_DE(dea), .o_HSYNC(hsa), .o_VSYNC(vsa),
    .o_FRAME_START(fsa), .o_FRAME_CNT(cnta)
  );

  vga_sync_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b1)
  ) u_dut_b (
    .i_CLK(clk), .i_RST(rst_b), .i_EN(en_b),
    .o_X(xb), .o_Y(yb), .o_DE(deb), .o_HSYNC(hsb), .o_VSYNC(vsb),
    .o_FRAME_START(fsb), .o_FRAME_CNT(cntb)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    int unsigned n;
    int unsigned x;
    int unsigned y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    int unsigned cnt;
  } vec_t;

  out_t act_a, act_b;
  assign act_a = {xa, ya, dea, hsa, vsa, fsa, cnta};
  assign act_b = {xb, yb, deb, hsb, vsb, fsb, cntb};

  int total = 0;
  int bad   = 0;
  longint unsigned na = 0, nb = 0;
  logic fsa_m = 1'b0, fsb_m = 1'b0;

  // n enabled edges since reset; reset parks the counters one edge before (0,0).
  function automatic out_t model(input int unsigned ha, hf, hsw, hb, va, vf, vsw, vb,
                                 input logic pol, input longint unsigned n, input logic fs);
    longint unsigned ht, vt, f, p, x, y;
    out_t o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    f  = ht * vt;
    p  = (n + f - 1) % f;
    x  = p % ht;
    y  = p / ht;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.de  = (x < ha) && (y < va);
    o.hs  = ((x >= ha + hf) && (x < ha + hf + hsw)) ? pol : ~pol;
    o.vs  = ((y >= va + vf) && (y < va + vf + vsw)) ? pol : ~pol;
    o.fs  = fs;
    o.cnt = 8'((n + f - 1) / f);
    return o;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b cnt=%0d expected x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b cnt=%0d",
               name, act.x, act.y, act.de, act.hs, act.vs, act.fs, act.cnt,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.fs, exp.cnt);
    end
  endtask

  // Called at a falling edge; applies one rising edge and compares both instances.
  task automatic step(input logic ea, input logic eb);
    en_a = ea;
    en_b = eb;
    @(posedge clk);
    if (rst_a) begin
      na = 0; fsa_m = 1'b0;
    end else begin
      if (ea) na++;
      fsa_m = ea && (((na - 1) % FA) == 0);
    end
    if (rst_b) begin
      nb = 0; fsb_m = 1'b0;
    end else begin
      if (eb) nb++;
      fsb_m = eb && (((nb - 1) % FB) == 0);
    end
    @(negedge clk);
    check_out("model_a", act_a, model(AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b0, na, fsa_m));
    check_out("model_b", act_b, model(BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, nb, fsb_m));
  endtask

  task automatic check_reset_vals();
    check("rst x_a", xa, 799);
    check("rst y_a", ya, 524);
    check("rst de_a", dea, 0);
    check("rst hs_a", hsa, 1);
    check("rst vs_a", vsa, 1);
    check("rst fs_a", fsa, 0);
    check("rst cnt_a", cnta, 0);
    check("rst x_b", xb, 13);
    check("rst y_b", yb, 6);
    check("rst hs_b", hsb, 0);
    check("rst vs_b", vsb, 0);
    check("rst cnt_b", cntb, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    int   cnt;
    int   x0;
    bit   seen;
    longint unsigned target;

    vecs[0]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[1]  = '{2,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{640,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[3]  = '{641,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{656,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[5]  = '{657,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{752,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[7]  = '{753,  752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{800,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[9]  = '{801,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{1601, 0,   2, 1'b1, 1'b1, 1'b1, 1'b0, 1};

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 11; i++) begin
      while (na < vecs[i].n) step(1'b1, 1'($urandom_range(0, 1)));
      check($sformatf("vec%0d.x", i), xa, vecs[i].x);
      check($sformatf("vec%0d.y", i), ya, vecs[i].y);
      check($sformatf("vec%0d.de", i), dea, vecs[i].de);
      check($sformatf("vec%0d.hs", i), hsa, vecs[i].hs);
      check($sformatf("vec%0d.vs", i), vsa, vecs[i].vs);
      check($sformatf("vec%0d.fs", i), fsa, vecs[i].fs);
      check($sformatf("vec%0d.cnt", i), cnta, vecs[i].cnt);
    end

    // Count DE and active HSYNC over one full line starting at X=0.
    cnt = 32'(dea);
    x0  = 32'(!hsa);
    for (int i = 0; i < 799; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      cnt += 32'(dea);
      x0  += 32'(!hsa);
    end
    check("de cycles per line", cnt, 640);
    check("hsync cycles per line", x0, 96);

    // Asynchronous reset mid-line, observed before any clock edge.
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check_reset_vals();
    step(1'b1, 1'b1);
    check_reset_vals();
    rst_a = 1'b0; rst_b = 1'b0;
    step(1'b1, 1'b1);
    check("post-rst x", xa, 0);
    check("post-rst y", ya, 0);
    check("post-rst de", dea, 1);
    check("post-rst fs", fsa, 1);
    check("post-rst cnt", cnta, 1);
    step(1'b0, 1'b0);
    check("hold fs", fsa, 0);
    check("hold x", xa, 0);
    check("hold cnt", cnta, 1);

    // One-in-four enable.
    for (int i = 0; i < 3200; i++) step(i % 4 == 0, $urandom_range(0, 3) != 0);
    x0 = int'(xa);
    for (int i = 0; i < 40; i++) step(i % 4 == 0, 1'b0);
    check("gated x advance", int'(xa) - x0, 10);

    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step(1'b0, i % 4 == 0);
      if (fsb) seen = 1'b1;
    end
    check("gated fs seen", seen, 1);
    step(1'b0, 1'b0);
    check("gated fs width", fsb, 0);

    // Small instance: active-high syncs over one line and one frame.
    while (!(xb == 0 && yb == 0)) step(1'b0, 1'b1);
    cnt = 0;
    x0  = 0;
    for (int i = 0; i < 98; i++) begin
      if (i < 14) cnt += 32'(hsb);
      x0 += 32'(vsb);
      step(1'b0, 1'b1);
    end
    check("small hsync high per line", cnt, 2);
    check("small vsync high per frame", x0, 14);

    // Run the small instance to its 256th frame start.
    target = 255 * FB + 1;
    for (int g = 0; g < 60000 && nb < target - 1; g++) step(1'b0, 1'b1);
    check("cnt before wrap", cntb, 255);
    step(1'b0, 1'b1);
    check("cnt after wrap", cntb, 0);
    check("fs at wrap", fsb, 1);
    step(1'b0, 1'b0);
    check("fs after wrap", fsb, 0);
    check("cnt hold after wrap", cntb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
